// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/halt controller.
// FSM state constants, the SYSTEM opcode, the drain length and the load-use hazard test.
package pipeline_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StRun    = 2'd0;
  localparam state_t StDrain  = 2'd1;
  localparam state_t StHalted = 2'd2;

  localparam logic [6:0] OPC_SYSTEM   = 7'h73;
  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  function automatic logic load_use_hazard(
    input logic       ex_is_load,
    input logic       ex_nop,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs1,
    input logic       id_use_rs2
  );
    return ex_is_load && !ex_nop && (ex_rd != 5'd0) &&
           (((ex_rd == id_rs1) && id_use_rs1) || ((ex_rd == id_rs2) && id_use_rs2));
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Pair of saturating event counters for stall and flush cycles.
// Width is parameterised so the counters can be narrowed when needed.
module pipe_perf_cnt #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [Width-1:0] stall_cnt,
  output logic [Width-1:0] flush_cnt
);

  logic [Width-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stage-register control: load-use stalls, redirect flushes and SYSTEM drain/halt.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_nop,
  input  logic [6:0]  ex_opcode,
  input  logic        ex_redirect,
  input  logic        resume,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_nop,
  output logic        id_ex_we,
  output logic        id_ex_nop,
  output logic        halted,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  state_t     state_q, state_d;
  logic [1:0] drain_q, drain_d;
  logic       halted_q;
  logic       is_system, is_redirect, is_load_use;

  assign is_system   = (ex_opcode == OPC_SYSTEM) && !ex_nop;
  assign is_redirect = ex_redirect && !ex_nop;
  assign is_load_use = load_use_hazard(ex_is_load, ex_nop, ex_rd, id_rs1, id_rs2,
                                       id_use_rs1, id_use_rs2);

  always_comb begin
    pc_we     = 1'b1;
    if_id_we  = 1'b1;
    if_id_nop = 1'b0;
    id_ex_we  = 1'b1;
    id_ex_nop = 1'b0;
    state_d   = state_q;
    drain_d   = drain_q;
    case (state_q)
      StRun: begin
        if (is_system) begin
          pc_we     = 1'b0;
          if_id_nop = 1'b1;
          id_ex_nop = 1'b1;
          state_d   = StDrain;
          drain_d   = DRAIN_CYCLES;
        end else if (is_redirect) begin
          if_id_nop = 1'b1;
          id_ex_nop = 1'b1;
        end else if (is_load_use) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_nop = 1'b1;
        end
      end
      StDrain: begin
        pc_we     = 1'b0;
        if_id_nop = 1'b1;
        id_ex_nop = 1'b1;
        drain_d   = (drain_q == 2'd0) ? 2'd0 : drain_q - 2'd1;
        // Halt once the count reaches zero on this cycle's decrement.
        if (drain_q <= 2'd1) state_d = StHalted;
      end
      StHalted: begin
        pc_we    = 1'b0;
        if_id_we = 1'b0;
        id_ex_we = 1'b0;
        if (resume) state_d = StRun;
      end
      default: begin
        state_d = StRun;
        drain_d = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      drain_q  <= 2'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == StHalted);
    end
  end

  assign halted = halted_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_ev, flush_ev;

  // Events mirror the RUN-state priority so only the winning action is counted.
  assign flush_ev = (state_q == StRun) && !is_system && is_redirect;
  assign stall_ev = (state_q == StRun) && !is_system && !is_redirect && is_load_use;

  pipe_perf_cnt #(
    .Width (32)
  ) u_perf (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (stall_ev),
    .flush_inc (flush_ev),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then randomized cycles
// compared against a behavioural model of the controller rules.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load, ex_nop, ex_redirect, resume;
  logic [6:0]  ex_opcode;
  logic        pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop, halted;
  logic [31:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  // Model: mode 0 = running, 1 = draining, 2 = halted.
  int     m_mode = 0;
  int     m_left = 0;
  longint m_stall = 0;
  longint m_flush = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_nop      (ex_nop),
    .ex_opcode   (ex_opcode),
    .ex_redirect (ex_redirect),
    .resume      (resume),
    .pc_we       (pc_we),
    .if_id_we    (if_id_we),
    .if_id_nop   (if_id_nop),
    .id_ex_we    (id_ex_we),
    .id_ex_nop   (id_ex_nop),
    .halted      (halted),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

`ifdef PIPE_PERF_CNT_EN
  logic       sat_rst, sat_stall, sat_flush;
  logic [1:0] sat_stall_cnt, sat_flush_cnt;

  pipe_perf_cnt #(
    .Width (2)
  ) u_sat (
    .clk       (clk),
    .rst       (sat_rst),
    .stall_inc (sat_stall),
    .flush_inc (sat_flush),
    .stall_cnt (sat_stall_cnt),
    .flush_cnt (sat_flush_cnt)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_is_load = 1'b0; ex_nop = 1'b0; ex_opcode = 7'h13;
    ex_redirect = 1'b0; resume = 1'b0;
  endtask

  // Expected outputs for the current model mode and inputs, plus next-mode bookkeeping.
  task automatic check_and_advance();
    bit sys, red, lu;
    logic [4:0] e_ctrl; // {pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop}
    logic [31:0] e_stall, e_flush;
    sys = (ex_opcode == 7'h73) && !ex_nop;
    red = ex_redirect && !ex_nop;
    lu  = ex_is_load && !ex_nop && ex_rd != 0 &&
          ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
    if (m_mode == 2)      e_ctrl = 5'b00000;
    else if (m_mode == 1) e_ctrl = 5'b01111;
    else if (sys)         e_ctrl = 5'b01111;
    else if (red)         e_ctrl = 5'b11111;
    else if (lu)          e_ctrl = 5'b00011;
    else                  e_ctrl = 5'b11010;
`ifdef PIPE_PERF_CNT_EN
    e_stall = 32'(m_stall);
    e_flush = 32'(m_flush);
`else
    e_stall = 32'd0;
    e_flush = 32'd0;
`endif
    check("ctrl", {27'd0, pc_we, if_id_we, if_id_nop, id_ex_we, id_ex_nop}, {27'd0, e_ctrl});
    check("halted", {31'd0, halted}, {31'd0, m_mode == 2});
    check("stall_cnt", stall_cnt, e_stall);
    check("flush_cnt", flush_cnt, e_flush);
    if (rst) begin
      m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 0) begin
      if (sys) begin
        m_mode = 1; m_left = 2;
      end else if (red) begin
        if (m_flush < 64'hFFFF_FFFF) m_flush++;
      end else if (lu) begin
        if (m_stall < 64'hFFFF_FFFF) m_stall++;
      end
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = 2;
    end else if (resume) begin
      m_mode = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_and_advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // Load x5 followed by a dependent read of rs1.
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // Load to x0 never stalls.
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    cycle();

    // Redirect wins over a simultaneous load-use.
    ex_is_load = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; ex_redirect = 1'b1;
    cycle();
    idle_inputs();
    cycle();

    // SYSTEM: three cycles of pc_we=0 then HALTED until resume.
    ex_opcode = 7'h73;
    cycle();
    idle_inputs();
    ex_redirect = 1'b1; resume = 1'b1;
    cycle();
    cycle();
    idle_inputs();
    check("halted_after_drain", {31'd0, halted}, 32'd1);
    cycle();
    cycle();
    resume = 1'b1;
    cycle();
    idle_inputs();
    check("resumed", {31'd0, halted}, 32'd0);
    cycle();

    // Reset during the second drain cycle.
    ex_opcode = 7'h73;
    cycle();
    idle_inputs();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("rst_drain_stall", stall_cnt, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      id_rs1      = 5'($urandom_range(3));
      id_rs2      = 5'($urandom_range(3));
      id_use_rs1  = 1'($urandom_range(1));
      id_use_rs2  = 1'($urandom_range(1));
      ex_rd       = 5'($urandom_range(3));
      ex_is_load  = ($urandom_range(2) == 0);
      ex_nop      = ($urandom_range(7) == 0);
      ex_opcode   = ($urandom_range(15) == 0) ? 7'h73 : 7'($urandom_range(127));
      ex_redirect = ($urandom_range(5) == 0);
      resume      = ($urandom_range(3) == 0);
      rst         = ($urandom_range(63) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

`ifdef PIPE_PERF_CNT_EN
    // Saturation on a narrow counter: max-1 plus two increments holds at max.
    sat_rst = 1'b1; sat_stall = 1'b0; sat_flush = 1'b0;
    @(posedge clk); #1;
    sat_rst = 1'b0; sat_stall = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("sat_preload", {30'd0, sat_stall_cnt}, 32'd2);
    repeat (2) begin @(posedge clk); #1; end
    check("sat_stall", {30'd0, sat_stall_cnt}, 32'd3);
    check("sat_flush_idle", {30'd0, sat_flush_cnt}, 32'd0);
    sat_stall = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
